// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES slices, carry registered
// between slices. Define PIPE_RCA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_rca_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SW = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipelined_rca_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    // Lo: result bits finished by earlier slices; Rem: operand bits not yet summed.
    localparam int unsigned Lo  = k * SW;
    localparam int unsigned Rem = WIDTH - Lo;

    logic [Rem-1:0]     a_in;
    logic [Rem-1:0]     b_in;
    logic               carry_in;
    logic               v_in;
    logic [SW:0]        s;
    logic [Lo+SW-1:0]   lo_next;

    assign s = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, carry_in};

    if (k == 0) begin : g_src
      assign a_in     = a;
      assign b_in     = b_eff;
      assign carry_in = c_eff;
      assign v_in     = in_valid;
      assign lo_next  = s[SW-1:0];
    end else begin : g_src
      assign a_in     = g_slice[k-1].g_reg.a_q;
      assign b_in     = g_slice[k-1].g_reg.b_q;
      assign carry_in = g_slice[k-1].g_reg.c_q;
      assign v_in     = g_slice[k-1].g_reg.v_q;
      assign lo_next  = {s[SW-1:0], g_slice[k-1].g_reg.lo_q};
    end

    if (k < STAGES - 1) begin : g_reg
      // Operand bits for the higher slices travel alongside the partial sum.
      logic [Rem-SW-1:0] a_q;
      logic [Rem-SW-1:0] b_q;
      logic [Lo+SW-1:0]  lo_q;
      logic              c_q;
      logic              v_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q  <= '0;
          b_q  <= '0;
          lo_q <= '0;
          c_q  <= 1'b0;
          v_q  <= 1'b0;
        end else if (en) begin
          a_q  <= a_in[Rem-1:SW];
          b_q  <= b_in[Rem-1:SW];
          lo_q <= lo_next;
          c_q  <= s[SW];
          v_q  <= v_in;
        end
      end
    end else begin : g_out
`ifdef PIPE_RCA_OVF_EN
      // Carry into the MSB recovered from the MSB's own sum bit.
      logic c_msb;
      assign c_msb = s[SW-1] ^ a_in[SW-1] ^ b_in[SW-1];
`endif

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
`ifdef PIPE_RCA_OVF_EN
          ovf       <= 1'b0;
`endif
        end else if (en) begin
          out_valid <= v_in;
          sum       <= lo_next;
          cout      <= s[SW];
`ifdef PIPE_RCA_OVF_EN
          ovf       <= c_msb ^ s[SW];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Scoreboard bench for pipelined_rca_adder (WIDTH=16, STAGES=4): driver pushes hand-computed
// results with their due enabled-edge count; a negedge monitor pops and checks them.
module tb_pipelined_rca_adder;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  pipelined_rca_adder #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_RCA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifndef PIPE_RCA_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   ecnt   = 0;
  logic adv    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Count of edges that actually advanced the pipeline.
  always @(posedge clk) begin
    adv <= en && rst_n;
    if (en && rst_n) ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    if (adv) begin
      if (sb.size() != 0 && sb[0].due == ecnt) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_valid", {31'b0, out_valid}, 32'd1);
        chk("sum", {16'b0, sum}, {16'b0, e.s});
        chk("cout", {31'b0, cout}, {31'b0, e.c});
`ifdef PIPE_RCA_OVF_EN
        chk("ovf", {31'b0, ovf}, {31'b0, e.o});
`endif
      end else begin
        chk("no_result_due", {31'b0, out_valid}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                       input logic ts, input logic [15:0] es, input logic ec, input logic eo);
    exp_t e;
    a        = ta;
    b        = tb_v;
    cin      = tc;
    sub      = ts;
    in_valid = 1'b1;
    e.s      = es;
    e.c      = ec;
    e.o      = eo;
    e.due    = ecnt + STAGES;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    sub      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sum", {16'b0, sum}, 32'd0);
    chk("reset_cout", {31'b0, cout}, 32'd0);
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Carry rippling through every slice.
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    idle(5);

    // Back-to-back adds.
    issue(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    issue(16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    idle(5);

    // Subtract; cin is ignored in subtract mode.
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    issue(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    issue(16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    idle(5);

    // Stall: P emerges just before en drops and must hold; Y finishes after resume.
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    idle(1);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    idle(1);
    en = 1'b0;
    a  = 16'h1111;
    b  = 16'h2222;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_sum", {16'b0, sum}, 32'h0100);
      chk("stall_cout", {31'b0, cout}, 32'd0);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    en = 1'b1;
    idle(6);

    // Reset mid-flight with en low: reset must still win and drop both operations.
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    rst_n = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    chk("midrst_sum", {16'b0, sum}, 32'd0);
    chk("midrst_cout", {31'b0, cout}, 32'd0);
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    sb.delete();
    rst_n = 1'b1;
    en    = 1'b1;
    idle(8);

    // Pipeline still works after reset.
    issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/pipelined_rca_adder.md
Name: pipelined_rca_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. Successor to the fixed 4-bit, 2-stage adder.
- WIDTH-bit operands are split into STAGES equal slices. Each slice ripples through full adders, and its carry is registered into the next slice. Operands for higher slices are skewed through delay registers.
- Adds a valid qualifier, a pipeline stall, a subtract mode and a reset.
- Used as the shared arithmetic datapath for accumulators and counters.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages/slices; 1 <= STAGES <= WIDTH; slice width SW = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  pipeline advance enable; 0 = stall (all registers hold).
- in_valid  input  1  operands valid this cycle.
- a  input  WIDTH  operand A (unsigned/two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add mode only).
- sub  input  1  1 = subtract (a - b), 0 = add (a + b + cin).
- out_valid  output  1  sum/cout valid.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of MSB (in subtract mode: 1 = no borrow).

Behaviour:
- Reset: with rst_n=0 at a rising edge, every pipeline register, valid bit, sum, cout (and ovf) clears to 0. Reset overrides en. Data in flight is discarded; no out_valid pulse is ever produced for it.
- Operand conditioning, combinational at input:
  - b_eff = sub ? ~b : b.
  - c_eff = sub ? 1 : cin.
  - sub and cin are consumed only at slice 0.
- Slice k (k = 0..STAGES-1) covers bits [k*SW +: SW]:
  - Slice 0 computes from raw a, b_eff, c_eff.
  - Slice k>0 computes from its operand bits delayed k edges and the registered carry of slice k-1.
  - Lower-slice sum bits are delayed to align at the output.
  - Final slice outputs are registered into sum/cout.
- Latency:
  - Operand accepted on rising edge t (en=1) produces its result on sum/cout/out_valid immediately after edge t+STAGES-1, counting only edges with en=1.
  - STAGES=1 is a single registered adder with latency 1.
- Throughput: one operation per enabled cycle; back-to-back in_valid fully supported.
- Valid: in_valid is shifted alongside the data. Data registers load regardless of in_valid. out_valid=0 marks sum/cout as don't-care for the checker, though they still reflect pipeline contents.
- Stall: en=0 holds every register, including out_valid and outputs. Inputs are ignored that cycle. Resuming preserves ordering and values exactly.
- Arithmetic: result = (a + b_eff + c_eff) mod 2^WIDTH; cout = bit WIDTH of the full sum. No saturation.
- Simultaneous rst_n=0 and en=0: reset wins.
- Illegal parameters (WIDTH % STAGES != 0): elaboration error via generate-time check.

Optional Feature:
- Macro PIPE_RCA_OVF_EN.
- Defined: adds output port ovf (1 bit) = signed two's-complement overflow (carry into MSB XOR carry out of MSB). Registered in the final stage with the same latency and stall behaviour as sum. Reset value 0.
- Undefined: port absent; no overflow logic.

Test Plan (WIDTH=16, STAGES=4, en=1 unless stated):
- Carry ripple across all slices: reset, then a=0xFFFF, b=0x0001, cin=0, sub=0, in_valid=1 on edge t -> at edge t+3: sum=0x0000, cout=1, out_valid=1. Before that, out_valid=0.
- Back-to-back add: three consecutive operations (0x1234+0x1111, cin=1; 0x00FF+0x0001; 0x8000+0x8000) -> on consecutive cycles: 0x2346/cout0, 0x0100/cout0, 0x0000/cout1.
- Subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0. a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
- Stall: issue 0xFFFF+0x0001, drop en for 5 cycles after edge t+1 -> result appears at edge t+8. Outputs constant during stall.
- Reset mid-flight: issue two operations, assert rst_n=0 for one edge at t+2 -> sum=0, cout=0, out_valid=0, and no stale out_valid afterwards.
- With PIPE_RCA_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1. 0xFFFF+0x0001 -> ovf=0.
